// File: rtl/viking_vmux_if.sv
// viking_vmux_if
//   Bundles the two video sources feeding the output selector and the
//   selected video leaving it.
//
//   Stream semantics: this is a free-running pixel stream. Every signal is
//   valid on every rising pclk edge. There is no valid/ready pair and no
//   backpressure, because a VGA monitor cannot stall.
//
//   Ports (slave = selector, master = whoever drives the sources):
//     viking_en               request Viking output (level)
//     st_hs, st_vs            shifter syncs, active low
//     st_r, st_g, st_b        shifter colour, 4 bits each
//     vk_hs, vk_vs            Viking syncs, active low
//     vk_r, vk_g, vk_b        Viking colour, 4 bits each
//     hs, vs                  selected syncs, active low
//     r, g, b                 selected colour
//     active                  Viking currently on the pins
//     sync_err                sticky Viking-vsync-lost flag
//     dbg_state               selector FSM state, for observation
interface viking_vmux_if;
  logic       viking_en;
  logic       st_hs;
  logic       st_vs;
  logic [3:0] st_r;
  logic [3:0] st_g;
  logic [3:0] st_b;
  logic       vk_hs;
  logic       vk_vs;
  logic [3:0] vk_r;
  logic [3:0] vk_g;
  logic [3:0] vk_b;
  logic       hs;
  logic       vs;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       active;
  logic       sync_err;
  logic [2:0] dbg_state;

  modport master (
    output viking_en, st_hs, st_vs, st_r, st_g, st_b,
           vk_hs, vk_vs, vk_r, vk_g, vk_b,
    input  hs, vs, r, g, b, active, sync_err, dbg_state
  );

  modport slave (
    input  viking_en, st_hs, st_vs, st_r, st_g, st_b,
           vk_hs, vk_vs, vk_r, vk_g, vk_b,
    output hs, vs, r, g, b, active, sync_err, dbg_state
  );
endinterface

// File: rtl/viking_vmux.sv
// viking_vmux
//   Selects between shifter video and Viking mono video for the VGA pins.
//   The source is switched only at frame boundaries. RGB is forced black for
//   BLANK_FRAMES frames around each switch so the monitor can re-lock. If the
//   Viking vsync stops for TIMEOUT pclk cycles, the output falls back to the
//   shifter and the sticky sync_err flag is set.
//
//   Ports:
//     pclk    pixel clock, rising edge
//     reset   asynchronous, active-high reset
//     vif     viking_vmux_if.slave: source inputs, selected outputs, debug state
//
//   Pipeline: stage A registers every input. Stage B registers the output,
//   using the mux chosen by the current state. Both sources therefore have
//   the same 2-pclk latency.
module viking_vmux #(
  parameter int BLANK_FRAMES = 2,
  parameter int TIMEOUT      = 4194304
) (
  input logic          pclk,
  input logic          reset,
  viking_vmux_if.slave vif
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_ST       = 3'd0,
    S_WAIT_VK  = 3'd1,
    S_BLANK_VK = 3'd2,
    S_VK       = 3'd3,
    S_BLANK_ST = 3'd4
  } state_t;

  // Stage A
  logic        r_a_en;
  logic        r_a_st_hs, r_a_st_vs, r_a_vk_hs, r_a_vk_vs;
  logic [11:0] r_a_st_rgb, r_a_vk_rgb;
  logic        r_st_vs_hist, r_vk_vs_hist;

  // Control
  state_t          r_state, w_state_next;
  logic [3:0]      r_frames, w_frames_next;
  logic [WD_W-1:0] r_wd, w_wd_next;
  logic            r_sync_err, w_sync_err_next;
  logic            r_active;
  logic            w_st_fall, w_vk_fall, w_wd_hit, w_frames_last;

  // Stage B
  logic        r_hs, r_vs;
  logic [11:0] r_rgb;
  logic        w_hs, w_vs, w_use_vk;
  logic [11:0] w_rgb;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_a_en       <= 1'b0;
      r_a_st_hs    <= 1'b1;
      r_a_st_vs    <= 1'b1;
      r_a_vk_hs    <= 1'b1;
      r_a_vk_vs    <= 1'b1;
      r_a_st_rgb   <= '0;
      r_a_vk_rgb   <= '0;
      r_st_vs_hist <= 1'b1;
      r_vk_vs_hist <= 1'b1;
    end else begin
      r_a_en       <= vif.viking_en;
      r_a_st_hs    <= vif.st_hs;
      r_a_st_vs    <= vif.st_vs;
      r_a_vk_hs    <= vif.vk_hs;
      r_a_vk_vs    <= vif.vk_vs;
      r_a_st_rgb   <= {vif.st_r, vif.st_g, vif.st_b};
      r_a_vk_rgb   <= {vif.vk_r, vif.vk_g, vif.vk_b};
      r_st_vs_hist <= r_a_st_vs;
      r_vk_vs_hist <= r_a_vk_vs;
    end
  end

  // History resets high, so a vsync that is low at reset release does not
  // count as a frame edge.
  assign w_st_fall     = !r_a_st_vs && r_st_vs_hist;
  assign w_vk_fall     = !r_a_vk_vs && r_vk_vs_hist;
  assign w_frames_last = (r_frames == 4'(BLANK_FRAMES - 1));
  assign w_wd_hit      = (r_state inside {S_WAIT_VK, S_BLANK_VK, S_VK}) &&
                         (r_wd == WD_W'(TIMEOUT - 1));

  always_comb begin
    w_state_next    = r_state;
    w_frames_next   = r_frames;
    w_sync_err_next = r_sync_err;
    w_wd_next       = '0;
    case (r_state)
      S_ST: begin
        if (r_a_en && !r_sync_err) w_state_next = S_WAIT_VK;
      end
      S_WAIT_VK: begin
        if (!r_a_en) begin
          w_state_next = S_ST;
        end else if (w_vk_fall) begin
          w_state_next  = S_BLANK_VK;
          w_frames_next = '0;
        end
      end
      S_BLANK_VK: begin
        // A request drop beats a frame edge that would have finished the blank.
        if (!r_a_en) begin
          w_state_next  = S_BLANK_ST;
          w_frames_next = '0;
        end else if (w_vk_fall) begin
          if (w_frames_last) w_state_next = S_VK;
          else               w_frames_next = r_frames + 4'd1;
        end
      end
      S_VK: begin
        if (!r_a_en) begin
          w_state_next  = S_BLANK_ST;
          w_frames_next = '0;
        end
      end
      S_BLANK_ST: begin
        if (w_st_fall) begin
          if (w_frames_last) w_state_next = S_ST;
          else               w_frames_next = r_frames + 4'd1;
        end
      end
      default: w_state_next = S_ST;
    endcase

    // The watchdog overrides any same-cycle transition.
    if (w_wd_hit) begin
      w_state_next    = S_BLANK_ST;
      w_frames_next   = '0;
      w_sync_err_next = 1'b1;
    end
    if (!r_a_en) w_sync_err_next = 1'b0;

    // The watchdog only runs while staying inside the Viking-side states.
    // Entering S_WAIT_VK from S_ST therefore starts it at zero.
    if ((r_state inside {S_WAIT_VK, S_BLANK_VK, S_VK}) &&
        (w_state_next inside {S_WAIT_VK, S_BLANK_VK, S_VK}) && !w_vk_fall)
      w_wd_next = r_wd + 1'b1;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state    <= S_ST;
      r_frames   <= '0;
      r_wd       <= '0;
      r_sync_err <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_frames   <= w_frames_next;
      r_wd       <= w_wd_next;
      r_sync_err <= w_sync_err_next;
      r_active   <= (w_state_next == S_VK);
    end
  end

  // The output mux follows the registered state. A state change therefore
  // reaches the pins one pclk after the edge that caused it.
  always_comb begin
    w_use_vk = (r_state == S_BLANK_VK) || (r_state == S_VK);
    w_hs     = w_use_vk ? r_a_vk_hs : r_a_st_hs;
    w_vs     = w_use_vk ? r_a_vk_vs : r_a_st_vs;
    w_rgb    = '0;
    if (r_state == S_ST)      w_rgb = r_a_st_rgb;
    else if (r_state == S_VK) w_rgb = r_a_vk_rgb;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_rgb <= '0;
    end else begin
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_rgb <= w_rgb;
    end
  end

  assign vif.hs        = r_hs;
  assign vif.vs        = r_vs;
  assign vif.r         = r_rgb[11:8];
  assign vif.g         = r_rgb[7:4];
  assign vif.b         = r_rgb[3:0];
  assign vif.active    = r_active;
  assign vif.sync_err  = r_sync_err;
  assign vif.dbg_state = r_state;
endmodule

// File: tb/tb_viking_vmux.sv
// tb_viking_vmux
//   Drives free-running shifter and Viking video patterns. It walks the
//   selector through its switch, blank, fallback and cancel cases. Each
//   driven pixel pushes its expected output, two pclk later, into a queue.
//   A negedge monitor pops and compares.
module tb_viking_vmux;
  localparam int BF      = 2;
  localparam int TMO     = 1000;
  localparam int ST_PER  = 30;
  localparam int VK_PER  = 40;

  typedef enum int {M_ST, M_WAIT, M_BVK, M_VK, M_BST} mode_t;

  logic pclk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;

  // Each entry is {observe cycle[31:0], hs, vs, r, g, b, active, sync_err}.
  logic [47:0] exp_q[$];

  // Stimulus state. m is the expected state once this pixel's events have
  // been taken. prev_m selects the data path for this pixel.
  mode_t m, prev_m;
  logic  exp_err;
  logic  push_en;
  logic  vk_run;
  logic  drv_en;
  int    st_cnt, vk_cnt;

  viking_vmux_if vif ();

  viking_vmux #(.BLANK_FRAMES(BF), .TIMEOUT(TMO)) dut (
    .pclk  (pclk),
    .reset (reset),
    .vif   (vif)
  );

  // Clock and cycle counter
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge pclk) begin
    logic [47:0] item;
    logic [15:0] got;
    if (exp_q.size() != 0) begin
      item = exp_q[0];
      got  = {vif.hs, vif.vs, vif.r, vif.g, vif.b, vif.active, vif.sync_err};
      if ($signed(item[47:16]) == cyc) begin
        void'(exp_q.pop_front());
        n_checks++;
        if (got !== item[15:0]) begin
          n_errors++;
          $display("FAIL out cyc=%0d got hs,vs,rgb,act,err=%h expected=%h",
                   cyc, got, item[15:0]);
        end
      end else if ($signed(item[47:16]) < cyc) begin
        void'(exp_q.pop_front());
        n_checks++;
        n_errors++;
        $display("FAIL stale cyc=%0d entry for cyc %0d never compared",
                 cyc, item[47:16]);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    logic        hs_e, vs_e, use_vk;
    logic [11:0] rgb_e, st_rgb, vk_rgb;
    for (int i = 0; i < n; i++) begin
      vif.viking_en = drv_en;
      vif.st_vs = (st_cnt < 3) ? 1'b0 : 1'b1;
      vif.st_hs = ((st_cnt % 10) < 2) ? 1'b0 : 1'b1;
      vif.st_r  = 4'(st_cnt);
      vif.st_g  = ~4'(st_cnt);
      vif.st_b  = 4'(st_cnt >> 1);
      vif.vk_vs = (vk_run && vk_cnt < 2) ? 1'b0 : 1'b1;
      vif.vk_hs = ((vk_cnt % 8) == 0) ? 1'b0 : 1'b1;
      vif.vk_r  = vk_cnt[0] ? 4'hF : 4'h0;
      vif.vk_g  = vif.vk_r;
      vif.vk_b  = vif.vk_r;
      if (push_en) begin
        st_rgb = {vif.st_r, vif.st_g, vif.st_b};
        vk_rgb = {vif.vk_r, vif.vk_g, vif.vk_b};
        use_vk = (prev_m == M_BVK) || (prev_m == M_VK);
        hs_e   = use_vk ? vif.vk_hs : vif.st_hs;
        vs_e   = use_vk ? vif.vk_vs : vif.st_vs;
        rgb_e  = (prev_m == M_ST) ? st_rgb : (prev_m == M_VK) ? vk_rgb : 12'h000;
        exp_q.push_back({32'(cyc + 2), hs_e, vs_e, rgb_e, (m == M_VK), exp_err});
      end
      prev_m = m;
      st_cnt = (st_cnt == ST_PER - 1) ? 0 : st_cnt + 1;
      vk_cnt = (vk_cnt == VK_PER - 1) ? 0 : vk_cnt + 1;
      @(posedge pclk);
      #1;
    end
  endtask

  // Advance until the next tick would drive a vsync falling edge.
  task automatic until_vk_fall();
    while (!(vk_run && vk_cnt == 0)) tick(1);
  endtask

  task automatic until_st_fall();
    while (st_cnt != 0) tick(1);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [15:0] got;
    got = {vif.hs, vif.vs, vif.r, vif.g, vif.b, vif.active, vif.sync_err};
    n_checks++;
    if (got !== 16'hC000) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", name, got, 16'hC000);
    end
  endtask

  // Two shifter frames of blank, then back to the shifter.
  task automatic blank_back_to_st();
    until_st_fall();
    tick(1);
    until_st_fall();
    m = M_ST;
    tick(1);
  endtask

  // Raise the request and follow it all the way to Viking output.
  task automatic go_vk();
    drv_en = 1'b1;
    m = M_WAIT;
    tick(1);
    until_vk_fall();
    m = M_BVK;
    tick(1);
    until_vk_fall();
    tick(1);
    until_vk_fall();
    m = M_VK;
    tick(1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m        = M_ST;
    prev_m   = M_ST;
    exp_err  = 1'b0;
    push_en  = 1'b0;
    vk_run   = 1'b1;
    drv_en   = 1'b0;
    st_cnt   = 7;
    vk_cnt   = 13;
    reset    = 1'b1;
    #1;
    check_reset_outputs("reset_initial");
    @(posedge pclk);
    #1;
    tick(3);
    reset   = 1'b0;
    push_en = 1'b1;
    tick(40);

    // Reset mid-frame: outputs go to idle immediately.
    push_en = 1'b0;
    tick(3);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("reset_midframe");
    @(posedge pclk);
    #1;
    check_reset_outputs("reset_held");
    tick(3);
    reset   = 1'b0;
    m       = M_ST;
    prev_m  = M_ST;
    push_en = 1'b1;
    tick(40);

    // Switch to Viking, run, then switch back.
    go_vk();
    tick(60);
    drv_en = 1'b0;
    m = M_BST;
    tick(1);
    blank_back_to_st();
    tick(40);

    // Viking vsync stops: fallback after TIMEOUT cycles without an edge.
    go_vk();
    vk_run = 1'b0;
    tick(TMO - 1);
    m = M_BST;
    exp_err = 1'b1;
    tick(1);
    vk_run = 1'b1;
    blank_back_to_st();
    tick(100);
    drv_en = 1'b0;
    exp_err = 1'b0;
    tick(5);
    drv_en = 1'b1;
    m = M_WAIT;
    tick(1);
    until_vk_fall();
    m = M_BVK;
    tick(6);
    drv_en = 1'b0;
    m = M_BST;
    tick(1);
    blank_back_to_st();

    // Cancel while waiting for the first Viking edge.
    until_vk_fall();
    tick(1);
    drv_en = 1'b1;
    m = M_WAIT;
    tick(5);
    drv_en = 1'b0;
    m = M_ST;
    tick(30);

    // Request drop lands on the same pixel as the final blank edge.
    drv_en = 1'b1;
    m = M_WAIT;
    tick(1);
    until_vk_fall();
    m = M_BVK;
    tick(1);
    until_vk_fall();
    tick(1);
    until_vk_fall();
    drv_en = 1'b0;
    m = M_BST;
    tick(1);
    blank_back_to_st();
    tick(20);

    push_en = 1'b0;
    tick(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain queue left=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/viking_vmux.md
# viking_vmux

Output selector between the ST/STE shifter video and the Viking/SM194 1280x1024 mono video, sitting directly downstream of the Viking generator in the top level. It switches the VGA pins between the two sources only at frame boundaries, blanks RGB for a programmable number of frames around each switch so the monitor can re-lock, and falls back to the shifter if the Viking vertical sync disappears.

## Interface
Parameters:
- BLANK_FRAMES, default 2: frames of forced black after a source change (1..15).
- TIMEOUT, default 4194304: pclk cycles without a Viking vs falling edge before fallback; counter width is clog2(TIMEOUT)+1.

Ports:
- pclk  in  1  pixel clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- viking_en  in  1  request Viking output (level, from config register).
- st_hs, st_vs  in  1 each  shifter syncs, active low.
- st_r, st_g, st_b  in  4 each  shifter colour.
- vk_hs, vk_vs  in  1 each  Viking syncs, active low.
- vk_r, vk_g, vk_b  in  4 each  Viking colour.
- hs, vs  out  1 each  selected syncs, active low, registered.
- r, g, b  out  4 each  selected colour, registered.
- active  out  1  high while state is S_VK.
- sync_err  out  1  sticky fallback flag.

## Operation
- All inputs registered once (stage A); outputs registered from stage A (stage B). Edge detect: st_fall = st_vs_A low and previous high; vk_fall likewise on vk_vs_A.
- States:
  - S_ST: out = shifter syncs + colour. viking_en=1 and sync_err=0 -> S_WAIT_VK.
  - S_WAIT_VK: out = shifter syncs, rgb=0. vk_fall -> S_BLANK_VK, frame counter := 0. viking_en=0 -> S_ST.
  - S_BLANK_VK: out = Viking syncs, rgb=0. Each vk_fall increments frame counter; when the counter reaches BLANK_FRAMES-1 on a vk_fall -> S_VK. viking_en=0 -> S_BLANK_ST.
  - S_VK: out = Viking syncs + colour. viking_en=0 -> S_BLANK_ST.
  - S_BLANK_ST: out = shifter syncs, rgb=0. Counts st_fall the same way; on the BLANK_FRAMES-th edge -> S_ST. viking_en is ignored here.
- Frame counter cleared on every entry to S_BLANK_VK and S_BLANK_ST.
- Watchdog: active in S_WAIT_VK, S_BLANK_VK and S_VK.
  - Cleared on vk_fall and on entry to S_WAIT_VK; otherwise increments.
  - Reaching TIMEOUT-1 -> S_BLANK_ST and sync_err := 1. Watchdog wins over a same-cycle vk_fall transition.
- sync_err cleared only when viking_en=0 (any state). While set, S_ST does not leave.
- Simultaneous viking_en fall and state-advancing vk_fall in S_BLANK_VK: viking_en wins (-> S_BLANK_ST).
- Watchdog inactive in S_ST and S_BLANK_ST; it holds 0.

## Timing
- Reset (async assert): state S_ST, hs=1, vs=1, r=g=b=0, active=0, sync_err=0, counters 0, edge-detect history = 1 (no spurious edge after release).
- Data latency: input to output = 2 pclk for syncs and colour in every state; the same for both sources, so sync/colour alignment is preserved.
- Mux select is taken from the state register. The state changes on the cycle the qualifying edge is detected in stage A. The first output cycle of the new source appears 1 pclk later.
- active and sync_err are registered and change on the same edge as the output select.
- Switch latency to Viking: the first vk_fall after request, plus BLANK_FRAMES Viking frames. Switch latency back: BLANK_FRAMES shifter frames.

## Test plan
- Reset mid-frame with vk/st running: hs=vs=1 and rgb=0 immediately. After release, the outputs equal the st inputs delayed 2 pclk, and active=0.
- Raise viking_en with BLANK_FRAMES=2:
  - Rgb stays 0 until the first vk_fall. After that, Viking syncs appear with rgb=0 for 2 Viking frames.
  - Then active=1 and r/g/b = vk delayed 2 pclk (0xF on set pixels).
- Drop viking_en in S_VK: shifter syncs and rgb=0 appear next cycle. After 2 st_fall edges the output is shifter colour and active=0.
- TIMEOUT=1000 in the bench, stop vk_vs in S_VK: after 999 pclk without vk_fall, state goes to S_BLANK_ST and sync_err=1. Toggling vk_vs afterwards does not reselect Viking. viking_en=0 clears sync_err; re-raising it restarts the switch.
- Drop viking_en in S_WAIT_VK before any vk_fall: immediate return to S_ST with no blank frames.
- Drop viking_en on the same cycle as the final vk_fall in S_BLANK_VK: the state goes to S_BLANK_ST and active never asserts.
